// File: rtl/udp_iq_pkg.sv
// Shared types and constants for the UDP I/Q receive unpacker.
package udp_iq_pkg;

    // Receive FSM: waiting for a header, or consuming payload words
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } rx_state_t;

    // Header word fields
    localparam int SEQ_MSB = 31;
    localparam int SEQ_LSB = 16;
    localparam int LEN_MSB = 15;
    localparam int LEN_LSB = 0;

    // Scale restored on receive; the transmit side removes it with >>>4
    localparam int DEF_SHIFT = 4;

endpackage

// File: rtl/udp_iq_stat_cnt.sv
// Saturating statistics counter with synchronous clear.
module udp_iq_stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count increment strobes, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/udp_iq_rx_unpack.sv
// UDP I/Q receive unpacker: parses the one-word header, streams scaled
// I/Q samples, checks framing/length/sequence and keeps link statistics.
module udp_iq_rx_unpack
    import udp_iq_pkg::*;
#(
    parameter int SHIFT = DEF_SHIFT,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         in_dat,
    input  logic                in_valid,
    input  logic                in_sop,
    input  logic                in_eop,
    output logic signed [15:0]  out_i,
    output logic signed [15:0]  out_q,
    output logic                out_valid,
    output logic                out_last,
    output logic                pkt_done,
    output logic                pkt_err,
    output logic                seq_gap,
    output logic [CNT_W-1:0]    cnt_ok,
    output logic [CNT_W-1:0]    cnt_err,
    output logic [CNT_W-1:0]    cnt_gap
);

    rx_state_t   r_state;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic [15:0] r_prev_seq;
    logic        r_seq_armed;   // a previous header exists to compare against
    logic        r_lerr;        // words arrived beyond the announced length

    logic [15:0]        w_seq;
    logic [15:0]        w_len;
    logic [15:0]        w_seq_exp;
    logic [15:0]        w_cnt_inc;
    logic               w_fwd;
    logic signed [15:0] w_i;
    logic signed [15:0] w_q;

    assign w_seq     = in_dat[SEQ_MSB:SEQ_LSB];
    assign w_len     = in_dat[LEN_MSB:LEN_LSB];
    assign w_seq_exp = r_prev_seq + 16'd1;
    // r_cnt only advances while below r_len, so this never wraps
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_fwd     = in_valid && !in_sop && (r_state == ST_PAYLOAD) && (r_cnt < r_len);
    // Transmit range guarantees the shifted value fits; no saturation needed
    assign w_i       = in_dat[31:16] << SHIFT;
    assign w_q       = in_dat[15:0] << SHIFT;

    // Framing FSM, header latch, sequence check and end-of-packet status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_prev_seq  <= '0;
            r_seq_armed <= 1'b0;
            r_lerr      <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_err     <= 1'b0;
            seq_gap     <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            seq_gap  <= 1'b0;
            if (in_valid) begin
                if (in_sop) begin
                    r_len       <= w_len;
                    r_cnt       <= '0;
                    r_lerr      <= 1'b0;
                    r_prev_seq  <= w_seq;
                    r_seq_armed <= 1'b1;
                    seq_gap     <= r_seq_armed && (w_seq != w_seq_exp);
                    // A header inside a packet aborts it as an error
                    if (r_state == ST_PAYLOAD) begin
                        pkt_done <= 1'b1;
                        pkt_err  <= 1'b1;
                    end
                    if (in_eop) begin
                        // Single-word packet; if it also aborted one, the
                        // shared pulse reports the abort error
                        pkt_done <= 1'b1;
                        pkt_err  <= (r_state == ST_PAYLOAD) || (w_len != '0);
                        r_state  <= ST_IDLE;
                    end else begin
                        r_state  <= ST_PAYLOAD;
                    end
                end else if (r_state == ST_PAYLOAD) begin
                    if (w_fwd) begin
                        r_cnt  <= w_cnt_inc;
                    end else begin
                        r_lerr <= 1'b1;
                    end
                    if (in_eop) begin
                        pkt_done <= 1'b1;
                        pkt_err  <= r_lerr || !w_fwd || (w_cnt_inc != r_len);
                        r_state  <= ST_IDLE;
                    end
                end
            end
        end
    end

    // Sample path: scale and forward words that fall inside the announced length
    always_ff @(posedge clk) begin
        if (rst) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= w_fwd;
            out_last  <= w_fwd && (in_eop || (w_cnt_inc == r_len));
            if (w_fwd) begin
                out_i <= w_i;
                out_q <= w_q;
            end
        end
    end

    logic w_ok_inc;
    logic w_err_inc;

    assign w_ok_inc  = pkt_done && !pkt_err;
    assign w_err_inc = pkt_done && pkt_err;

    udp_iq_stat_cnt #(.CNT_W(CNT_W)) u_cnt_ok (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_ok_inc),
        .o_cnt (cnt_ok)
    );

    udp_iq_stat_cnt #(.CNT_W(CNT_W)) u_cnt_err (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_err_inc),
        .o_cnt (cnt_err)
    );

    udp_iq_stat_cnt #(.CNT_W(CNT_W)) u_cnt_gap (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (seq_gap),
        .o_cnt (cnt_gap)
    );

endmodule

// File: tb/tb_udp_iq_rx_unpack.sv
// Self-checking bench for udp_iq_rx_unpack: packet-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_udp_iq_rx_unpack;

    localparam int SHIFT = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic [31:0]      in_dat = '0;
    logic             in_valid = 1'b0;
    logic             in_sop = 1'b0;
    logic             in_eop = 1'b0;
    logic [15:0]      out_i;
    logic [15:0]      out_q;
    logic             out_valid;
    logic             out_last;
    logic             pkt_done;
    logic             pkt_err;
    logic             seq_gap;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_err;
    logic [CNT_W-1:0] cnt_gap;

    udp_iq_rx_unpack #(.SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_dat    (in_dat),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_last  (out_last),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err),
        .seq_gap   (seq_gap),
        .cnt_ok    (cnt_ok),
        .cnt_err   (cnt_err),
        .cnt_gap   (cnt_gap)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state (packet level)
    bit          m_in_pkt    = 1'b0;
    bit          m_have_prev = 1'b0;
    int          m_n         = 0;
    int          m_words     = 0;
    logic [15:0] m_prev      = '0;
    logic [15:0] m_i         = '0;
    logic [15:0] m_q         = '0;

    // Expectations for the outputs after the coming edge, and current ones
    logic [15:0] nx_i = '0, nx_q = '0;
    bit          nx_v = 0, nx_l = 0, nx_d = 0, nx_e = 0, nx_g = 0;
    logic [15:0] ex_i = '0, ex_q = '0;
    bit          ex_v = 0, ex_l = 0, ex_d = 0, ex_e = 0, ex_g = 0;
    int          ex_ok = 0, ex_err = 0, ex_gap = 0;
    bit          chk_en = 1'b0;

    int seen_gap   = 0;
    int seen_valid = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int c, input bit inc);
        return (inc && c < CMAX) ? c + 1 : c;
    endfunction

    // Sample restore as plain signed arithmetic: value * 2^SHIFT, low 16 bits kept
    function automatic logic [15:0] scale(input logic [15:0] x);
        int t;
        t = int'(signed'(x)) * (1 << SHIFT);
        return t[15:0];
    endfunction

    // Advance model expectations with the clock; counters lag the pulses by one cycle
    always @(posedge clk) begin
        ex_ok  <= rst ? 0 : sat_inc(ex_ok,  ex_d && !ex_e);
        ex_err <= rst ? 0 : sat_inc(ex_err, ex_d &&  ex_e);
        ex_gap <= rst ? 0 : sat_inc(ex_gap, ex_g);
        ex_i <= nx_i; ex_q <= nx_q;
        ex_v <= nx_v; ex_l <= nx_l; ex_d <= nx_d; ex_e <= nx_e; ex_g <= nx_g;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_i",     32'(out_i),     32'(ex_i));
            chk("out_q",     32'(out_q),     32'(ex_q));
            chk("out_valid", 32'(out_valid), 32'(ex_v));
            chk("out_last",  32'(out_last),  32'(ex_v & ex_l));
            chk("pkt_done",  32'(pkt_done),  32'(ex_d));
            if (ex_d) chk("pkt_err", 32'(pkt_err), 32'(ex_e));
            chk("seq_gap",   32'(seq_gap),   32'(ex_g));
            chk("cnt_ok",    32'(cnt_ok),    ex_ok);
            chk("cnt_err",   32'(cnt_err),   ex_err);
            chk("cnt_gap",   32'(cnt_gap),   ex_gap);
        end
    end

    // Drive one cycle and compute what the outputs must be after it
    task automatic step(input bit r, input bit v, input bit s, input bit e, input logic [31:0] d);
        logic [15:0] seq;
        int idx;
        rst = r; in_valid = v; in_sop = s; in_eop = e; in_dat = d;
        nx_v = 0; nx_l = 0; nx_d = 0; nx_e = 0; nx_g = 0;
        if (r) begin
            m_in_pkt = 0; m_have_prev = 0; m_i = '0; m_q = '0;
        end else if (v) begin
            if (s) begin
                seq  = d[31:16];
                nx_g = m_have_prev && (int'(seq) != (int'(m_prev) + 1) % 65536);
                m_prev = seq; m_have_prev = 1;
                if (m_in_pkt) begin nx_d = 1; nx_e = 1; end
                m_n = int'(d[15:0]); m_words = 0;
                if (e) begin
                    nx_d = 1; nx_e = nx_e || (m_n != 0); m_in_pkt = 0;
                end else begin
                    m_in_pkt = 1;
                end
            end else if (m_in_pkt) begin
                idx = m_words;
                m_words++;
                if (idx < m_n) begin
                    nx_v = 1;
                    m_i  = scale(d[31:16]);
                    m_q  = scale(d[15:0]);
                    nx_l = e || (idx + 1 == m_n);
                end
                if (e) begin nx_d = 1; nx_e = (m_words != m_n); m_in_pkt = 0; end
            end
        end
        nx_i = m_i; nx_q = m_q;
        @(posedge clk);
        #1;
        seen_gap   += int'(seq_gap);
        seen_valid += int'(out_valid);
    endtask

    task automatic hdr(input logic [15:0] seq, input logic [15:0] n, input bit e);
        step(0, 1, 1, e, {seq, n});
    endtask

    task automatic word(input logic [31:0] d, input bit e);
        step(0, 1, 0, e, d);
    endtask

    // Invalid cycle with junk on data and framing lines
    task automatic idle();
        step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 32'h0);
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_i",     32'(out_i),     0);
        chk("rst_cnt_ok",    32'(cnt_ok),    0);

        // Nominal 3-word packet
        hdr(16'h0001, 16'd3, 0);
        chk("A_hdr_gap", 32'(seq_gap), 0);
        word(32'h0001_FFFF, 0);
        chk("A_s0_i", 32'(out_i), 32'h0010);
        chk("A_s0_q", 32'(out_q), 32'hFFF0);
        chk("A_s0_last", 32'(out_last), 0);
        word(32'h07FF_F800, 0);
        chk("A_s1_i", 32'(out_i), 32'h7FF0);
        chk("A_s1_q", 32'(out_q), 32'h8000);
        word(32'h0000_0000, 1);
        chk("A_s2_i", 32'(out_i), 0);
        chk("A_s2_last", 32'(out_last), 1);
        chk("A_done", 32'(pkt_done), 1);
        chk("A_err", 32'(pkt_err), 0);
        idle();
        chk("A_cnt_ok", 32'(cnt_ok), 1);
        chk("A_out_hold", 32'(out_valid), 0);

        // Short packet: N=4 but eop on second word
        seen_valid = 0;
        hdr(16'h0002, 16'd4, 0);
        word(32'h0003_0004, 0);
        idle();
        word(32'hFFFD_0001, 1);
        chk("B_done", 32'(pkt_done), 1);
        chk("B_err", 32'(pkt_err), 1);
        chk("B_last", 32'(out_last), 1);
        idle();
        chk("B_cnt_err", 32'(cnt_err), 1);
        chk("B_nsamp", seen_valid, 2);

        // Long packet: N=2 followed by 4 words
        seen_valid = 0;
        hdr(16'h0003, 16'd2, 0);
        word(32'h0011_0022, 0);
        word(32'h0033_0044, 0);
        chk("C_last2", 32'(out_last), 1);
        word(32'h0055_0066, 0);
        word(32'h0077_0088, 1);
        chk("C_err", 32'(pkt_err), 1);
        chk("C_nsamp", seen_valid, 2);
        chk("C_hold_i", 32'(out_i), 32'h0330);

        // Sequence wrap and a single gap
        do_reset();
        seen_gap = 0;
        hdr(16'hFFFE, 16'd0, 1);
        hdr(16'hFFFF, 16'd0, 1);
        hdr(16'h0000, 16'd0, 1);
        chk("S_wrap_gap", 32'(seq_gap), 0);
        hdr(16'h0002, 16'd0, 1);
        chk("S_gap", 32'(seq_gap), 1);
        idle();
        chk("S_seen_gap", seen_gap, 1);
        chk("S_cnt_gap", 32'(cnt_gap), 1);
        chk("S_cnt_ok", 32'(cnt_ok), 4);

        // Abort by a new header, without and with in_valid toggling
        for (int g = 0; g < 2; g++) begin
            do_reset();
            hdr(16'h0003, 16'd5, 0);
            if (g != 0) idle();
            word(32'h0100_0200, 0);
            if (g != 0) idle();
            word(32'h0300_0400, 0);
            if (g != 0) idle();
            hdr(16'h0004, 16'd1, 0);
            chk("X_abort_done", 32'(pkt_done), 1);
            chk("X_abort_err", 32'(pkt_err), 1);
            if (g != 0) idle();
            word(32'h0500_0600, 1);
            chk("X_new_done", 32'(pkt_done), 1);
            chk("X_new_err", 32'(pkt_err), 0);
            chk("X_new_i", 32'(out_i), 32'h5000);
            if (g != 0) idle();
            idle();
            chk("X_cnt_ok", 32'(cnt_ok), 1);
            chk("X_cnt_err", 32'(cnt_err), 1);
            chk("X_cnt_gap", 32'(cnt_gap), 0);
        end

        // Counter saturation
        do_reset();
        for (int k = 0; k < 9; k++) hdr(16'(k), 16'd1, 1);
        idle();
        chk("T_cnt_err_sat", 32'(cnt_err), CMAX);
        for (int k = 0; k < 9; k++) hdr(16'(100 + 2 * k), 16'd0, 1);
        idle();
        chk("T_cnt_ok_sat", 32'(cnt_ok), CMAX);
        chk("T_cnt_gap_sat", 32'(cnt_gap), CMAX);

        // Reset in the middle of a payload
        hdr(16'h0010, 16'd5, 0);
        word(32'h0123_0456, 0);
        word(32'h0789_0ABC, 0);
        step(1, 1, 0, 0, 32'h1234_5678);
        chk("R_out_i", 32'(out_i), 0);
        chk("R_out_q", 32'(out_q), 0);
        chk("R_valid", 32'(out_valid), 0);
        chk("R_cnt_ok", 32'(cnt_ok), 0);
        chk("R_cnt_err", 32'(cnt_err), 0);
        chk("R_cnt_gap", 32'(cnt_gap), 0);
        hdr(16'h1234, 16'd1, 0);
        chk("R_first_gap", 32'(seq_gap), 0);
        word(32'h0001_0002, 1);
        chk("R_done", 32'(pkt_done), 1);
        chk("R_err", 32'(pkt_err), 0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
